// File: rtl/playback_stream_checker.sv
// Buffered, valid-qualified expected-vs-actual stream checker with care masks and a PASS/FAIL verdict.
// Define PLAYBACK_CHECKER_DISPLAY_EN for per-bit mismatch and verdict messages in simulation.
module playback_stream_checker #(
  parameter int WIDTH       = 71,
  parameter int DEPTH       = 8,
  parameter int SKIP_CYCLES = 3,
  parameter int CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exp_valid,
  output logic                     exp_ready,
  input  logic [WIDTH-1:0]         exp_data,
  input  logic [WIDTH-1:0]         exp_mask,
  input  logic                     act_valid,
  input  logic [WIDTH-1:0]         act_data,
  input  logic                     eot,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         mismatch_cnt,
  output logic [CNT_W-1:0]         first_fail_cycle,
  output logic [WIDTH-1:0]         first_fail_diff,
  output logic                     fail,
  output logic                     underflow,
  output logic                     done,
  output logic                     pass
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] SKIP_CNT = CNT_W'(SKIP_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] fifo_data [DEPTH];
  logic [WIDTH-1:0] fifo_mask [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             push;
  logic             vld_p0;
  logic             pop_p0;
  logic             miss_p0;
  logic [WIDTH-1:0] diff_p0;

  // Stage p0: compare event against the FIFO head (an empty FIFO never bypasses a same-cycle push)
  assign exp_ready = !rst && (fifo_count != FULL_CNT);
  assign empty     = (fifo_count == '0);
  assign push      = exp_valid && exp_ready;
  assign vld_p0    = act_valid && (cycle_cnt >= SKIP_CNT) && !done;
  assign pop_p0    = vld_p0 && !empty;
  assign diff_p0   = empty ? '1 : ((fifo_data[rd_ptr] ^ act_data) & fifo_mask[rd_ptr]);
  assign miss_p0   = vld_p0 && (diff_p0 != '0);
  assign pass      = done && !fail && empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= exp_data;
      fifo_mask[wr_ptr] <= exp_mask;
    end
  end

  // Stage p1: registered results, visible the cycle after the event
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_count       <= '0;
      cycle_cnt        <= '0;
      mismatch_cnt     <= '0;
      first_fail_cycle <= '0;
      first_fail_diff  <= '0;
      fail             <= 1'b0;
      underflow        <= 1'b0;
      done             <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_p0)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop_p0})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      cycle_cnt <= sat_inc(cycle_cnt);
      if (miss_p0) begin
        mismatch_cnt <= sat_inc(mismatch_cnt);
        fail         <= 1'b1;
        if (!fail) begin
          first_fail_cycle <= cycle_cnt;
          first_fail_diff  <= diff_p0;
        end
      end
      if (vld_p0 && empty)
        underflow <= 1'b1;
      if (eot)
        done <= 1'b1;
    end
  end

`ifdef PLAYBACK_CHECKER_DISPLAY_EN
  logic done_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_seen <= 1'b0;
    end else begin
      done_seen <= done;
      if (miss_p0) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (diff_p0[i])
            $display("[checker] bit %0d expected %b got %b at cycle %0d",
                     i, fifo_data[rd_ptr][i], act_data[i], cycle_cnt);
        end
      end
      if (done && !done_seen)
        $display("[checker] %s mismatches=%0d", pass ? "PASSED" : "FAILED", mismatch_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_playback_stream_checker.sv
// Scoreboard bench: a queue-based reference model predicts every cycle's outputs for a 32-bit
// and a 4-bit counter instance driven by the same directed and random stimulus.
module tb_playback_stream_checker;

  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int SKIP  = 3;

  logic clk;
  logic rst, exp_valid, act_valid, eot;
  logic [W-1:0] exp_data, exp_mask, act_data;

  logic         d_exp_ready, d_fail, d_underflow, d_done, d_pass;
  logic [3:0]   d_fifo_count;
  logic [31:0]  d_cycle_cnt, d_mismatch_cnt, d_first_fail_cycle;
  logic [W-1:0] d_first_fail_diff;

  logic         s_exp_ready, s_fail, s_underflow, s_done, s_pass;
  logic [3:0]   s_fifo_count;
  logic [3:0]   s_cycle_cnt, s_mismatch_cnt, s_first_fail_cycle;
  logic [W-1:0] s_first_fail_diff;

  playback_stream_checker #(.WIDTH(W), .DEPTH(DEPTH), .SKIP_CYCLES(SKIP), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .exp_valid(exp_valid), .exp_ready(d_exp_ready),
    .exp_data(exp_data), .exp_mask(exp_mask), .act_valid(act_valid), .act_data(act_data),
    .eot(eot), .fifo_count(d_fifo_count), .cycle_cnt(d_cycle_cnt),
    .mismatch_cnt(d_mismatch_cnt), .first_fail_cycle(d_first_fail_cycle),
    .first_fail_diff(d_first_fail_diff), .fail(d_fail), .underflow(d_underflow),
    .done(d_done), .pass(d_pass));

  playback_stream_checker #(.WIDTH(W), .DEPTH(DEPTH), .SKIP_CYCLES(SKIP), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .exp_valid(exp_valid), .exp_ready(s_exp_ready),
    .exp_data(exp_data), .exp_mask(exp_mask), .act_valid(act_valid), .act_data(act_data),
    .eot(eot), .fifo_count(s_fifo_count), .cycle_cnt(s_cycle_cnt),
    .mismatch_cnt(s_mismatch_cnt), .first_fail_cycle(s_first_fail_cycle),
    .first_fail_diff(s_first_fail_diff), .fail(s_fail), .underflow(s_underflow),
    .done(s_done), .pass(s_pass));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: a plain queue of {data, mask} plus unbounded counters
  logic [15:0]  m_q[$];
  longint       m_cyc, m_mcnt, m_ffc;
  logic [W-1:0] m_ffd;
  bit           m_fail, m_under, m_done;

  typedef struct {
    int           cnt;
    longint       cyc, mcnt, ffc;
    logic [W-1:0] ffd;
    bit           fail, under, done;
  } snap_t;
  snap_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sat4(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_step(input bit r, input bit ev, input logic [W-1:0] ed,
                            input logic [W-1:0] em, input bit av,
                            input logic [W-1:0] ad, input bit eo);
    bit ready, evt, miss;
    logic [W-1:0] diff;
    logic [15:0] e;
    if (r) begin
      m_q.delete();
      m_cyc = 0; m_mcnt = 0; m_ffc = 0; m_ffd = '0;
      m_fail = 0; m_under = 0; m_done = 0;
      return;
    end
    ready = (m_q.size() < DEPTH);
    evt   = av && (m_cyc >= SKIP) && !m_done;
    miss  = 0;
    diff  = '0;
    if (evt) begin
      if (m_q.size() == 0) begin
        m_under = 1;
        diff    = '1;
        miss    = 1;
      end else begin
        e    = m_q.pop_front();
        diff = (e[15:8] ^ ad) & e[7:0];
        miss = (diff != 0);
      end
    end
    if (ev && ready)
      m_q.push_back({ed, em});
    if (miss) begin
      if (!m_fail) begin
        m_ffc = m_cyc;
        m_ffd = diff;
      end
      m_fail = 1;
      m_mcnt++;
    end
    m_cyc++;
    if (eo)
      m_done = 1;
  endtask

  task automatic tick(input bit r, input bit ev, input logic [W-1:0] ed,
                      input logic [W-1:0] em, input bit av,
                      input logic [W-1:0] ad, input bit eo);
    snap_t s;
    rst = r; exp_valid = ev; exp_data = ed; exp_mask = em;
    act_valid = av; act_data = ad; eot = eo;
    @(posedge clk);
    #1;
    model_step(r, ev, ed, em, av, ad, eo);
    s.cnt = m_q.size(); s.cyc = m_cyc; s.mcnt = m_mcnt; s.ffc = m_ffc; s.ffd = m_ffd;
    s.fail = m_fail; s.under = m_under; s.done = m_done;
    sb.push_back(s);
    rst = 1'b0; exp_valid = 1'b0; act_valid = 1'b0; eot = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
  endtask

  // Monitor: each mid-cycle, pop the predicted state and compare both instances
  initial begin
    snap_t s;
    bit exp_pass, exp_rdy;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        s = sb.pop_front();
        exp_pass = s.done && !s.fail && (s.cnt == 0);
        exp_rdy  = !rst && (s.cnt < DEPTH);
        chk("fifo_count",       64'(d_fifo_count),       64'(s.cnt));
        chk("exp_ready",        64'(d_exp_ready),        64'(exp_rdy));
        chk("cycle_cnt",        64'(d_cycle_cnt),        64'(s.cyc));
        chk("mismatch_cnt",     64'(d_mismatch_cnt),     64'(s.mcnt));
        chk("first_fail_cycle", 64'(d_first_fail_cycle), 64'(s.ffc));
        chk("first_fail_diff",  64'(d_first_fail_diff),  64'(s.ffd));
        chk("fail",             64'(d_fail),             64'(s.fail));
        chk("underflow",        64'(d_underflow),        64'(s.under));
        chk("done",             64'(d_done),             64'(s.done));
        chk("pass",             64'(d_pass),             64'(exp_pass));
        chk("s_fifo_count",     64'(s_fifo_count),       64'(s.cnt));
        chk("s_cycle_cnt",      64'(s_cycle_cnt),        64'(sat4(s.cyc)));
        chk("s_mismatch_cnt",   64'(s_mismatch_cnt),     64'(sat4(s.mcnt)));
        chk("s_first_fail_cyc", 64'(s_first_fail_cycle), 64'(sat4(s.ffc)));
        chk("s_fail",           64'(s_fail),             64'(s.fail));
        chk("s_pass",           64'(s_pass),             64'(exp_pass));
      end
    end
  end

  initial begin
    logic [W-1:0] ed, em, ad;
    bit r, ev, av, eo;
    rst = 1'b1; exp_valid = 1'b0; act_valid = 1'b0; eot = 1'b0;
    exp_data = '0; exp_mask = '0; act_data = '0;

    tick(1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    chk("reset_mismatch", 64'(d_mismatch_cnt), 64'd0);
    chk("reset_fifo",     64'(d_fifo_count),   64'd0);

    // Basic matching stream, pushes during warm-up, then eot
    for (int i = 0; i < 3; i++) tick(0, 1, 8'hA5, 8'hFF, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 8'h00, 8'h00, 1, 8'hA5, 0);
    tick(0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
    chk("t1_pass",     64'(d_pass),         64'd1);
    chk("t1_mismatch", 64'(d_mismatch_cnt), 64'd0);
    chk("t1_fifo",     64'(d_fifo_count),   64'd0);
    idle(2);

    // Masked low nibble, then a real single-bit miss
    tick(1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    tick(0, 1, 8'hA5, 8'hF0, 0, 8'h00, 0);
    idle(2);
    tick(0, 0, 8'h00, 8'h00, 1, 8'hAA, 0);
    chk("t2_masked", 64'(d_mismatch_cnt), 64'd0);
    tick(0, 1, 8'hA5, 8'hFF, 0, 8'h00, 0);
    tick(0, 0, 8'h00, 8'h00, 1, 8'hA4, 0);
    chk("t2_mismatch", 64'(d_mismatch_cnt),    64'd1);
    chk("t2_diff",     64'(d_first_fail_diff), 64'h01);

    // Fill to full with exp_valid held, then drain
    tick(1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) tick(0, 1, 8'(i * 17), 8'hFF, 0, 8'h00, 0);
    chk("t3_full_count", 64'(d_fifo_count), 64'd8);
    chk("t3_full_ready", 64'(d_exp_ready),  64'd0);
    for (int i = 0; i < 8; i++) tick(0, 0, 8'h00, 8'h00, 1, 8'(i * 17), 0);
    chk("t3_drained",  64'(d_fifo_count),   64'd0);
    chk("t3_no_miss",  64'(d_mismatch_cnt), 64'd0);

    // Underflow at cycle 5
    tick(1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    idle(5);
    tick(0, 0, 8'h00, 8'h00, 1, 8'h3C, 0);
    chk("t4_underflow", 64'(d_underflow),        64'd1);
    chk("t4_fail",      64'(d_fail),             64'd1);
    chk("t4_ff_cycle",  64'(d_first_fail_cycle), 64'd5);
    chk("t4_ff_diff",   64'(d_first_fail_diff),  64'hFF);

    // act_valid during warm-up is ignored
    tick(1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 8'h11, 8'hFF, 1, 8'hEE, 0);
    chk("t5_no_miss", 64'(d_mismatch_cnt), 64'd0);
    chk("t5_no_pop",  64'(d_fifo_count),   64'd3);

    // Mid-test reset with entries held and fail set
    idle(2);
    tick(0, 0, 8'h00, 8'h00, 1, 8'h22, 0);
    chk("t6_fail",  64'(d_fail),       64'd1);
    chk("t6_count", 64'(d_fifo_count), 64'd2);
    tick(0, 1, 8'h11, 8'hFF, 0, 8'h00, 0);
    tick(0, 1, 8'h11, 8'hFF, 0, 8'h00, 0);
    chk("t6_count4", 64'(d_fifo_count), 64'd4);
    tick(1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    chk("t6_rst_count", 64'(d_fifo_count),   64'd0);
    chk("t6_rst_fail",  64'(d_fail),         64'd0);
    chk("t6_rst_cycle", 64'(d_cycle_cnt),    64'd0);
    chk("t6_rst_diff",  64'(d_first_fail_diff), 64'd0);

    // Saturation of the 4-bit counters
    idle(3);
    for (int i = 0; i < 20; i++) tick(0, 0, 8'h00, 8'h00, 1, 8'h00, 0);
    chk("t6_sat4",  64'(s_mismatch_cnt), 64'd15);
    chk("t6_full32", 64'(d_mismatch_cnt), 64'd20);

    // Randomized traffic including resets, eot and pointer wrap
    tick(1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    for (int n = 0; n < 1500; n++) begin
      r  = ($urandom_range(0, 99) == 0);
      ev = ($urandom_range(0, 1) == 1);
      ed = 8'($urandom);
      em = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      av = ($urandom_range(0, 2) != 0);
      ad = (m_q.size() != 0) ? m_q[0][15:8] : 8'($urandom);
      if ($urandom_range(0, 3) == 0) ad = ad ^ 8'(1 << $urandom_range(0, 7));
      eo = ($urandom_range(0, 199) == 0);
      tick(r, ev, ed, em, av, ad, eo);
    end

    idle(1);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
